// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Message-level round-robin arbiter sharing one UART byte transmitter
//   between NUM_REQ byte-stream requesters. A requester owns the transmitter
//   for a whole message (until req_last or MAX_LEN bytes). Its bytes pass
//   through a one-entry output register, and an optional CR/LF terminator
//   follows each message.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   MAX_LEN     payload bytes per message before forced termination (1..255)
//   APPEND_CRLF 1: append 8'h0D, 8'h0A after every message
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/data/last  per-requester byte lanes (data lane i at [8i+7:8i])
//   req_ready         byte of requester i accepted this cycle
//   tx_valid/tx_data  output register towards the transmitter
//   tx_ready          transmitter accepts tx_data this cycle
//   grant             one-hot current owner, zero when no owner
//   busy              message in progress or byte pending
//   trunc             one-cycle pulse when a message hits MAX_LEN without last
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_LEN     = 64,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 trunc
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DATA, CR, LF} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [7:0]    cnt;

  logic          slot_free;
  logic          accept;
  logic          msg_end;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [7:0]    own_byte;
  logic          own_last;

  // The output register can take a new byte when empty or being drained now.
  assign slot_free = !tx_valid || tx_ready;
  assign req_ready = (state == DATA && slot_free) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE) || tx_valid;

  // Byte and last flag of the current owner.
  always_comb begin
    own_byte = '0;
    own_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        own_byte = req_data[8*i +: 8];
        own_last = req_last[i];
      end
    end
  end

  assign msg_end = own_last || (({1'b0, cnt} + 9'd1) == 9'(MAX_LEN));

  // First valid requester scanning from rr_ptr upward, wrapping at NUM_REQ.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      trunc    <= 1'b0;
    end else begin
      trunc <= 1'b0;
      // Default: a free slot that nothing loads this cycle ends up empty;
      // any load below overrides this.
      if (slot_free) begin
        tx_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant  <= NUM_REQ'(1) << win_idx;
            rr_ptr <= PW'((32'(win_idx) + 1) % NUM_REQ);
            cnt    <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            tx_valid <= 1'b1;
            tx_data  <= own_byte;
            cnt      <= cnt + 8'd1;
            if (msg_end) begin
              grant <= '0;
              trunc <= !own_last;
              state <= APPEND_CRLF ? CR : IDLE;
            end
          end
        end
        CR: begin
          if (slot_free) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h0D;
            state    <= LF;
          end
        end
        LF: begin
          if (slot_free) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h0A;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_LEN=4,
//   APPEND_CRLF=1). Requester byte streams are held in queues; a message
//   level reference model predicts the round-robin winner, the transmitted
//   byte stream (payload plus CR/LF), ownership and truncation pulses.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic [N-1:0]     grant;
  logic             busy;
  logic             trunc;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .MAX_LEN    (MAXL),
    .APPEND_CRLF(1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .grant    (grant),
    .busy     (busy),
    .trunc    (trunc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;

  ent_t       q [N][$];
  logic [7:0] exp_tx [$];
  logic [7:0] tx_log [$];
  int         win_log [$];
  logic [7:0] want [$];
  int         want_win [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_next, owner, rem, trunc_seen, trunc_exp, pending_trunc_cyc;
  bit cur_trunc;
  int grant_cyc, grant_high, first_txv;
  int acc_cnt [N];
  bit stall_mask [N];
  bit rand_stall;
  int tx_mode;
  logic [N-1:0] prev_valid, prev_grant;
  logic         prev_stall;
  logic [7:0]   prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    q[r].push_back(e);
  endtask

  // Winner is the first valid requester after the previous winner; the
  // message is read off that requester's pending stream.
  task automatic on_grant();
    int w = -1;
    int gi = -1;
    for (int k = 0; k < N; k++) begin
      int idx = (rr_next + k) % N;
      if (w < 0 && prev_valid[idx]) w = idx;
    end
    for (int i = 0; i < N; i++) if (grant[i]) gi = i;
    check("grant_rr", 32'(grant), (w < 0) ? 32'd0 : (32'd1 << w));
    win_log.push_back(gi);
    grant_cyc = cyc;
    if (w >= 0) begin
      rr_next   = (w + 1) % N;
      owner     = w;
      rem       = 0;
      cur_trunc = 1'b0;
      for (int j = 0; j < q[w].size(); j++) begin
        exp_tx.push_back(q[w][j].d);
        rem++;
        if (q[w][j].l) break;
        if (rem == MAXL) begin
          cur_trunc = 1'b1;
          trunc_exp++;
          break;
        end
      end
      exp_tx.push_back(8'h0D);
      exp_tx.push_back(8'h0A);
    end
  endtask

  task automatic step();
    logic slot;
    // outputs registered at the previous edge
    if (prev_stall) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_data", 32'(tx_data), 32'(prev_data));
    end
    check("trunc", 32'(trunc), 32'(cyc == pending_trunc_cyc));
    if (trunc === 1'b1) trunc_seen++;
    if (grant != '0) grant_high++;
    if (tx_valid === 1'b1 && first_txv < 0) first_txv = cyc;
    if (owner < 0 && prev_grant == '0 && grant != '0) on_grant();
    else check("grant", 32'(grant), (owner < 0) ? 32'd0 : (32'd1 << owner));
    // inputs for this cycle
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && !stall_mask[i] && !(rand_stall && $urandom_range(0, 4) == 0)) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = q[i][0].d;
        req_last[i]        = q[i][0].l;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    tx_ready = (tx_mode == 0) ? 1'b0 : (tx_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    slot = !tx_valid || tx_ready;
    check("req_ready", 32'(req_ready), (owner >= 0 && slot) ? (32'd1 << owner) : 32'd0);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(q[i].pop_front());
        acc_cnt[i]++;
        if (i == owner && rem > 0) begin
          rem--;
          if (rem == 0) begin
            if (cur_trunc) pending_trunc_cyc = cyc + 1;
            owner = -1;
          end
        end
      end
    end
    if (tx_valid && tx_ready) begin
      tx_log.push_back(tx_data);
      checks++;
      assert (exp_tx.size() != 0) else begin
        errors++;
        $error("FAIL tx_unexpected: observed byte %0h expected none", tx_data);
      end
      if (exp_tx.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_valid = req_valid;
    prev_grant = grant;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_trunc", 32'(trunc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      acc_cnt[i]    = 0;
      stall_mask[i] = 1'b0;
    end
    exp_tx.delete();
    tx_log.delete();
    win_log.delete();
    owner = -1; rem = 0; rr_next = 0; cur_trunc = 1'b0;
    trunc_seen = 0; trunc_exp = 0; pending_trunc_cyc = -1;
    grant_high = 0; first_txv = -1; grant_cyc = -1;
    prev_valid = '0; prev_grant = '0; prev_stall = 1'b0; prev_data = '0;
    rand_stall = 1'b0;
    tx_mode = 1;
  endtask

  function automatic bit drained();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (q[i].size() != 0) e = 1'b0;
    return e && exp_tx.size() == 0 && owner < 0 && busy === 1'b0;
  endfunction

  task automatic drain(input string tag, input int bound);
    for (int k = 0; k < bound && !drained(); k++) step();
    check(tag, 32'(drained()), 32'd1);
  endtask

  task automatic cmp_tx(input string tag);
    check({tag, "_len"}, 32'(tx_log.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < tx_log.size(); i++)
      check({tag, "_byte"}, 32'(tx_log[i]), 32'(want[i]));
  endtask

  task automatic cmp_win(input string tag);
    check({tag, "_len"}, 32'(win_log.size()), 32'(want_win.size()));
    for (int i = 0; i < want_win.size() && i < win_log.size(); i++)
      check({tag, "_win"}, 32'(win_log[i]), 32'(want_win[i]));
  endtask

  initial begin
    int s0, d0, a0, len;
    logic [7:0] b [6];

    // reset state
    do_reset();

    // single message "Hi" from requester 0
    push(0, 8'h48, 1'b0);
    push(0, 8'h69, 1'b1);
    s0 = cyc;
    step();
    for (int k = 0; k < 30 && tx_log.size() < 4; k++) step();
    want = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    cmp_tx("hi");
    check("hi_grant_lat", 32'(grant_cyc - s0), 32'd1);
    check("hi_txv_lat", 32'(first_txv - s0), 32'd2);
    check("hi_grant_cycles", 32'(grant_high), 32'd2);
    check("hi_busy_end", 32'(busy), 32'd0);

    // round robin: all requesters continuously valid, 1-byte messages
    do_reset();
    for (int r = 0; r < N; r++) begin
      push(r, 8'(8'h30 + r), 1'b1);
      push(r, 8'(8'h40 + r), 1'b1);
    end
    drain("rr_drain", 200);
    want_win = '{0, 1, 2, 3, 0, 1, 2, 3};
    cmp_win("rr");

    // backpressure mid-message
    do_reset();
    push(1, 8'hA1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hC3, 1'b1);
    for (int k = 0; k < 20 && tx_log.size() < 1; k++) step();
    tx_mode = 0;
    d0 = int'(tx_data);
    a0 = acc_cnt[1];
    repeat (10) step();
    check("bp_data", 32'(tx_data), 32'(d0));
    check("bp_valid", 32'(tx_valid), 32'd1);
    check("bp_no_accept", 32'(acc_cnt[1]), 32'(a0));
    tx_mode = 1;
    drain("bp_drain", 40);
    want = '{8'hA1, 8'hB2, 8'hC3, 8'h0D, 8'h0A};
    cmp_tx("bp");

    // truncation at MAX_LEN, remainder rearbitrated
    do_reset();
    for (int j = 0; j < 6; j++) begin
      b[j] = 8'($urandom);
      push(2, b[j], j == 5);
    end
    drain("tr_drain", 60);
    want = '{b[0], b[1], b[2], b[3], 8'h0D, 8'h0A, b[4], b[5], 8'h0D, 8'h0A};
    cmp_tx("tr");
    want_win = '{2, 2};
    cmp_win("tr");
    check("tr_pulses", 32'(trunc_seen), 32'd1);

    // owner stalls while another requester waits
    do_reset();
    push(0, 8'h61, 1'b0);
    push(0, 8'h62, 1'b0);
    push(0, 8'h63, 1'b1);
    push(1, 8'h78, 1'b1);
    for (int k = 0; k < 20 && acc_cnt[0] < 1; k++) step();
    stall_mask[0] = 1'b1;
    repeat (5) begin
      step();
      check("stall_grant", 32'(grant), 32'd1);
    end
    check("stall_waiter", 32'(acc_cnt[1]), 32'd0);
    stall_mask[0] = 1'b0;
    drain("stall_drain", 60);
    want = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A, 8'h78, 8'h0D, 8'h0A};
    cmp_tx("stall");
    want_win = '{0, 1};
    cmp_win("stall");

    // reset in the middle of a message
    do_reset();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    for (int k = 0; k < 20 && acc_cnt[1] < 1; k++) step();
    check("mid_pending", 32'(tx_valid), 32'd1);
    do_reset();
    repeat (6) step();
    check("mid_no_crlf", 32'(tx_log.size()), 32'd0);
    push(0, 8'h55, 1'b1);
    push(2, 8'h66, 1'b1);
    drain("mid_drain", 40);
    want_win = '{0, 2};
    cmp_win("mid");

    // randomized traffic with random backpressure and valid gaps
    do_reset();
    rand_stall = 1'b1;
    tx_mode = 2;
    for (int r = 0; r < N; r++) begin
      for (int m = 0; m < 6; m++) begin
        len = int'($urandom_range(1, 6));
        for (int j = 0; j < len; j++) push(r, 8'($urandom), j == len - 1);
      end
    end
    drain("rand_drain", 3000);
    check("rand_trunc", 32'(trunc_seen), 32'(trunc_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
